i2s_tdm_tx: RTL
===============

I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 16: valid data bits per channel sample.
REQ-002 SHALL have parameter SLOT_BITS, default 16: SCLK periods per channel slot; SLOT_BITS >= SAMPLE_BITS.
REQ-003 SHALL have parameter NUM_CHANNELS, default 2: slots per frame; even, >= 2.
REQ-004 SHALL have parameter SCLK_HALF, default 8: i_Clk cycles per SCLK half-period; >= 1.
REQ-005 SHALL have parameter MCLK_HALF, default 2: i_Clk cycles per MCLK half-period; >= 1.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: frame FIFO entries; power of two, >= 2.
REQ-007 SHALL have port i_Clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_Rst, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port i_Mode, input, 1: 0 = I2S (one-bit delay), 1 = left-justified.
REQ-010 SHALL have port i_Frame_Data, input, NUM_CHANNELS*SAMPLE_BITS: channel 0 in the LSB-side slice.
REQ-011 SHALL have port i_Frame_Valid, input, 1: frame-write request.
REQ-012 SHALL have port o_Frame_Ready, output, 1: FIFO not full.
REQ-013 SHALL have port o_Fifo_Level, output, $clog2(FIFO_DEPTH)+1: occupied entries.
REQ-014 SHALL have port o_Underflow, output, 1: one-cycle pulse when a frame starts with the FIFO empty.
REQ-015 SHALL have ports o_MCLK, o_SCLK, o_LRCLK, o_SDIN, each output, 1: the I2S/TDM serial bus.

Function
REQ-016 SHALL generate o_MCLK and o_SCLK as free-running 50% dividers using internal strobes, never as clocks for internal logic.
REQ-017 SHALL keep a bit counter 0..NUM_CHANNELS*SLOT_BITS-1 that advances on each SCLK falling strobe and wraps to 0.
REQ-018 SHALL pop one FIFO frame into the frame shift register, and latch i_Mode, on the falling strobe where the bit counter is 0.
REQ-019 SHALL load an all-zero frame and pulse o_Underflow for exactly one i_Clk cycle when the FIFO is empty at that pop point.
REQ-020 SHALL drive o_LRCLK low for slots 0..NUM_CHANNELS/2-1 and high for the remaining slots, updating on falling strobes.
REQ-021 SHALL transmit each sample MSB first, then zeros for the SLOT_BITS-SAMPLE_BITS padding bits.
REQ-022 SHALL change o_SDIN only on SCLK falling strobes.
REQ-023 SHALL, in left-justified mode, present each slot MSB in the same SCLK period as the slot boundary.
REQ-024 SHALL, in I2S mode, present each slot MSB one SCLK period after the slot boundary; the final bit of the last slot carries into bit 0 of the next frame.
REQ-025 SHALL apply an i_Mode change only at the next frame boundary.
REQ-026 SHALL accept a write when i_Frame_Valid and o_Frame_Ready are both high; o_Frame_Ready = (level < FIFO_DEPTH).
REQ-027 SHALL, on a simultaneous write and pop, keep the level unchanged; the pop uses pre-write state, so an empty FIFO still underflows.

Reset
REQ-028 SHALL, while i_Rst is high, hold o_MCLK, o_SCLK, o_LRCLK, o_SDIN, o_Underflow and o_Fifo_Level at 0, o_Frame_Ready at 1, and all counters and the FIFO cleared.
REQ-029 SHALL discard FIFO contents and any partial frame when reset is asserted mid-frame.
REQ-030 SHALL start the first frame, with bit counter 0, on the first SCLK falling strobe after reset release.

Structure
REQ-031 SHALL place the mode encodings (I2S, LJ) and the derived-width constant functions in shared package i2s_pkg.
REQ-032 SHALL implement the frame FIFO as sub-module i2s_frame_fifo (width NUM_CHANNELS*SAMPLE_BITS, depth FIFO_DEPTH, synchronous, first-word not fall-through).

Verification (defaults unless stated)
REQ-033 SHALL check: reset release -> SCLK period 16 i_Clk, LRCLK period 512 i_Clk, MCLK period 4 i_Clk.
REQ-034 SHALL check: write frame {R=16'h8001, L=16'hA5F0}, i_Mode=1 -> left slot shows A5F0 MSB first aligned to LRCLK fall; right slot shows 8001.
REQ-035 SHALL check: same frame with i_Mode=0 -> every bit delayed one SCLK; R LSB '1' appears in bit 0 of the next frame.
REQ-036 SHALL check: no writes -> o_Underflow pulses once per frame and o_SDIN stays 0.
REQ-037 SHALL check: 5 back-to-back writes -> o_Frame_Ready low after 4, level 4; 5th write blocked.
REQ-038 SHALL check: NUM_CHANNELS=4, SLOT_BITS=32, SAMPLE_BITS=24 -> LRCLK high for slots 2-3, 8 zero pad bits per slot, plus an i_Rst pulse mid-frame -> all outputs return to 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM transmitter.
// Contents:
//   mode_e  - serial framing mode (I2S one-bit delay or left-justified)
//   cnt_w   - width of a counter that must hold 0..n-1 (never below 1 bit)
//   lvl_w   - width of an occupancy count that must hold 0..depth
package i2s_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with a registered read port. The head entry is
// not visible until it is popped; rd_data holds the popped word from the
// cycle after rd_en until the next successful pop.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   wr_en, wr_data  - write request and data (ignored while full)
//   rd_en           - pop request (ignored while empty)
//   rd_data         - last popped word
//   full, empty     - occupancy flags
//   level           - number of occupied entries
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic [LW-1:0]    level_next_s;

  // Qualify requests against the current flags and compute the next level;
  // a simultaneous write and pop leaves the level unchanged.
  always_comb begin
    wr_ok_s      = wr_en && !full;
    rd_ok_s      = rd_en && !empty;
    level_next_s = level;
    if (wr_ok_s && !rd_ok_s) begin
      level_next_s = level + LW'(1);
    end else if (rd_ok_s && !wr_ok_s) begin
      level_next_s = level - LW'(1);
    end else begin
      level_next_s = level;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, registered flags and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rd_data  <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        rd_data  <= mem[rd_ptr_r];
      end
      level <= level_next_s;
      full  <= (level_next_s == DEPTH_L);
      empty <= (level_next_s == LW'(0));
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serial transmitter with a frame FIFO.
// Frames (all channels of one sample period) are queued through
// i_Frame_Data/i_Frame_Valid and serialised MSB first on o_SDIN, one slot
// per channel, with o_LRCLK low for the first half of the slots.
// Ports:
//   i_Clk, i_Rst          - system clock, asynchronous active-high reset
//   i_Mode                - 0 = I2S (one-bit delay), 1 = left-justified
//   i_Frame_Data          - one frame, channel 0 in the LSB-side slice
//   i_Frame_Valid         - frame write request
//   o_Frame_Ready         - FIFO can accept a frame
//   o_Fifo_Level          - occupied FIFO entries
//   o_Underflow           - one-cycle pulse when a frame starts with no data
//   o_MCLK, o_SCLK,
//   o_LRCLK, o_SDIN       - serial bus, all generated from i_Clk strobes
//
// Timing: a falling SCLK strobe pops the FIFO, whose data is only available
// one cycle later. The whole bus (SCLK, LRCLK, SDIN) is therefore produced
// one i_Clk cycle after the strobe, which keeps SDIN/LRCLK changing exactly
// on the SCLK falling edge seen on the pins.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS  = 16,
  parameter int SLOT_BITS    = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int SCLK_HALF    = 8,
  parameter int MCLK_HALF    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic                                i_Mode,
  input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0] i_Frame_Data,
  input  logic                                i_Frame_Valid,
  output logic                                o_Frame_Ready,
  output logic [$clog2(FIFO_DEPTH):0]         o_Fifo_Level,
  output logic                                o_Underflow,
  output logic                                o_MCLK,
  output logic                                o_SCLK,
  output logic                                o_LRCLK,
  output logic                                o_SDIN
);

  localparam int FRAME_W    = NUM_CHANNELS * SAMPLE_BITS;
  localparam int FRAME_BITS = NUM_CHANNELS * SLOT_BITS;
  localparam int BW         = cnt_w(FRAME_BITS);
  localparam int SW         = cnt_w(SCLK_HALF);
  localparam int MW         = cnt_w(MCLK_HALF);

  localparam logic [BW-1:0] LAST_POS  = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] RIGHT_POS = BW'((NUM_CHANNELS / 2) * SLOT_BITS);
  localparam logic [SW-1:0] SCLK_LAST = SW'(SCLK_HALF - 1);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);

  // Clock dividers
  logic [MW-1:0]         mclk_cnt_r;
  logic                  mclk_r;
  logic [SW-1:0]         sclk_cnt_r;
  logic                  sclk_ph_r;
  logic                  sclk_r;
  // Strobe stage
  logic [BW-1:0]         bit_cnt_r;
  logic                  fall_d_r;
  logic                  pop_d_r;
  logic                  pop_ok_d_r;
  logic [BW-1:0]         pos_d_r;
  mode_e                 mode_r;
  logic                  underflow_r;
  // Bus stage
  logic [FRAME_BITS-1:0] shreg_r;
  logic                  prev_bit_r;
  logic                  sdin_r;
  logic                  lrclk_r;
  // Combinational
  logic                  mclk_wrap_s;
  logic                  sclk_wrap_s;
  logic                  fall_stb_s;
  logic                  pop_stb_s;
  logic [FRAME_W-1:0]    fifo_data_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FRAME_BITS-1:0] padded_s;
  logic [FRAME_BITS-1:0] frame_bits_s;
  logic                  lj_bit_s;
  logic                  tx_bit_s;

  i2s_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .wr_en   (i_Frame_Valid),
    .wr_data (i_Frame_Data),
    .rd_en   (pop_stb_s),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (o_Fifo_Level)
  );

  assign o_Frame_Ready = !fifo_full_s;
  assign o_MCLK        = mclk_r;
  assign o_SCLK        = sclk_r;
  assign o_LRCLK       = lrclk_r;
  assign o_SDIN        = sdin_r;
  assign o_Underflow   = underflow_r;

  // Divider wrap points and the SCLK falling / frame-start strobes.
  always_comb begin
    mclk_wrap_s = (mclk_cnt_r == MCLK_LAST);
    sclk_wrap_s = (sclk_cnt_r == SCLK_LAST);
    fall_stb_s  = sclk_wrap_s && sclk_ph_r;
    pop_stb_s   = fall_stb_s && (bit_cnt_r == {BW{1'b0}});
  end

  // Free-running MCLK and SCLK dividers; SCLK leaves one cycle late to
  // line up with the data produced from the popped frame.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mclk_cnt_r <= '0;
      mclk_r     <= 1'b0;
      sclk_cnt_r <= '0;
      sclk_ph_r  <= 1'b0;
      sclk_r     <= 1'b0;
    end else begin
      if (mclk_wrap_s) begin
        mclk_cnt_r <= '0;
        mclk_r     <= ~mclk_r;
      end else begin
        mclk_cnt_r <= mclk_cnt_r + MW'(1);
      end
      if (sclk_wrap_s) begin
        sclk_cnt_r <= '0;
        sclk_ph_r  <= ~sclk_ph_r;
      end else begin
        sclk_cnt_r <= sclk_cnt_r + SW'(1);
      end
      sclk_r <= sclk_ph_r;
    end
  end

  // Bit position, FIFO pop bookkeeping, mode latch and underflow pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      bit_cnt_r   <= '0;
      fall_d_r    <= 1'b0;
      pop_d_r     <= 1'b0;
      pop_ok_d_r  <= 1'b0;
      pos_d_r     <= '0;
      mode_r      <= MODE_I2S;
      underflow_r <= 1'b0;
    end else begin
      if (fall_stb_s) begin
        bit_cnt_r <= (bit_cnt_r == LAST_POS) ? {BW{1'b0}} : bit_cnt_r + BW'(1);
      end
      if (pop_stb_s) begin
        mode_r <= mode_e'(i_Mode);
      end
      fall_d_r    <= fall_stb_s;
      pop_d_r     <= pop_stb_s;
      pop_ok_d_r  <= pop_stb_s && !fifo_empty_s;
      pos_d_r     <= bit_cnt_r;
      underflow_r <= pop_stb_s && fifo_empty_s;
    end
  end

  // Lay the popped frame out in transmit order: each slot holds its sample
  // MSB first followed by zero padding, slot 0 at the top.
  always_comb begin
    padded_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      padded_s[FRAME_BITS-1-c*SLOT_BITS -: SAMPLE_BITS] =
        fifo_data_s[c*SAMPLE_BITS +: SAMPLE_BITS];
    end
    if (pop_d_r) begin
      frame_bits_s = pop_ok_d_r ? padded_s : '0;
    end else begin
      frame_bits_s = shreg_r;
    end
    // The left-justified stream is always tracked; I2S sends it one bit
    // late, so the last bit of a frame spills into bit 0 of the next.
    lj_bit_s = frame_bits_s[FRAME_BITS-1];
    if (mode_r == MODE_LJ) begin
      tx_bit_s = lj_bit_s;
    end else begin
      tx_bit_s = prev_bit_r;
    end
  end

  // Serial bus update, one cycle after each SCLK falling strobe.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      shreg_r    <= '0;
      prev_bit_r <= 1'b0;
      sdin_r     <= 1'b0;
      lrclk_r    <= 1'b0;
    end else if (fall_d_r) begin
      shreg_r    <= {frame_bits_s[FRAME_BITS-2:0], 1'b0};
      prev_bit_r <= lj_bit_s;
      sdin_r     <= tx_bit_s;
      lrclk_r    <= (pos_d_r >= RIGHT_POS);
    end
  end

endmodule
